// File: rtl/bcd_disp_pkg.sv
// ---------------------------------------------------------------------------
// Package: bcd_disp_pkg
// Purpose: shared sizes, 7-segment glyph constants and small helpers for the
//          BCD display scanner and its glyph decoder.
//          Glyphs are stored active-high in {g,f,e,d,c,b,a} order. The top
//          level applies the board polarity at its output register.
// Contents:
//   BCD_DIGITS, BCD_W, SEG_W, WORD_W  - display geometry
//   SEG_0 .. SEG_9, SEG_DASH, SEG_BLANK - glyph patterns (active-high)
//   digit_idx_t                       - digit slot index type
//   hasBadNibble()                    - any nibble of a packed word > 9
//   anForDigit()                      - one-hot active-low digit enable
// ---------------------------------------------------------------------------
package bcd_disp_pkg;

   localparam int BCD_DIGITS = 4;
   localparam int BCD_W      = 4;
   localparam int SEG_W      = 7;
   localparam int WORD_W     = BCD_DIGITS * BCD_W;

   // Active-high glyphs, bit 6 = g ... bit 0 = a
   localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

   typedef logic [1:0] digit_idx_t;

   localparam digit_idx_t LAST_DIGIT = 2'd3;

   // True when any nibble of the packed word is outside the BCD range 0..9.
   function automatic logic hasBadNibble(input logic [WORD_W-1:0] word);
      logic bad;
      bad = 1'b0;
      for (int k = 0; k < BCD_DIGITS; k++) begin
         if (word[k*BCD_W +: BCD_W] > 4'd9) begin
            bad = 1'b1;
         end
      end
      return bad;
   endfunction

   // Digit enables are always active-low and one-hot; an[0] is the ones digit.
   function automatic logic [BCD_DIGITS-1:0] anForDigit(input digit_idx_t idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// Module: bcd_to_seg7
// Purpose: combinational decoder from one BCD nibble to an active-high
//          7-segment glyph. Values 0-9 give the usual digits, A-F give a
//          dash so an out-of-range digit is visible on the display, and the
//          blank flag overrides everything with an unlit slot.
// Ports:
//   i_nibble  in   4  BCD digit value
//   i_blank   in   1  force an unlit glyph (leading-zero suppression)
//   o_glyph   out  7  {g,f,e,d,c,b,a}, 1 = segment lit
// ---------------------------------------------------------------------------
module bcd_to_seg7
   import bcd_disp_pkg::*;
(
   input  logic [BCD_W-1:0] i_nibble,
   input  logic             i_blank,
   output logic [SEG_W-1:0] o_glyph
);

   // Blank wins over the digit value; any non-BCD code falls through to
   // the dash so bad upstream data is obvious rather than silently wrong.
   always_comb begin
      o_glyph = SEG_DASH;
      if (i_blank) begin
         o_glyph = SEG_BLANK;
      end else begin
         case (i_nibble)
            4'd0:    o_glyph = SEG_0;
            4'd1:    o_glyph = SEG_1;
            4'd2:    o_glyph = SEG_2;
            4'd3:    o_glyph = SEG_3;
            4'd4:    o_glyph = SEG_4;
            4'd5:    o_glyph = SEG_5;
            4'd6:    o_glyph = SEG_6;
            4'd7:    o_glyph = SEG_7;
            4'd8:    o_glyph = SEG_8;
            4'd9:    o_glyph = SEG_9;
            default: o_glyph = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// ---------------------------------------------------------------------------
// Module: bcd_display_scanner
// Purpose: accepts a packed 4-digit BCD word through a valid/ready handshake,
//          parks it in a one-word pending register and swaps it onto the
//          display only at a scan-frame boundary, so a frame never mixes
//          digits of two different words. The held word is time-multiplexed
//          onto a common-anode 4-digit 7-segment display.
// Parameters:
//   CLK_DIV         clk cycles per digit slot (>= 2); a frame is 4*CLK_DIV
//   SEG_ACTIVE_LOW  1: segment driven low = lit, 0: driven high = lit
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits (thousands,
//                          hundreds, tens) are shown unlit; the ones digit is
//                          always shown. Slots are still scanned.
// Ports:
//   clk         in   1   system clock, everything on posedge
//   rst_n       in   1   synchronous active-low reset
//   bcd_valid   in   1   bcd_number valid this cycle
//   bcd_number  in   16  {thousands,hundreds,tens,ones}
//   bcd_ready   out  1   pending slot free; transfer on valid && ready
//   seg         out  7   {g,f,e,d,c,b,a} segment drive
//   an          out  4   one-hot active-low digit enable, an[0] = ones
//   digit_err   out  1   displayed word holds a nibble above 9
// ---------------------------------------------------------------------------
module bcd_display_scanner
   import bcd_disp_pkg::*;
#(
   parameter int CLK_DIV        = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  bcd_valid,
   input  logic [WORD_W-1:0]     bcd_number,
   output logic                  bcd_ready,
   output logic [SEG_W-1:0]      seg,
   output logic [BCD_DIGITS-1:0] an,
   output logic                  digit_err
);

   localparam int              PRE_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

   // Pattern that leaves every segment dark for the chosen board polarity.
   localparam logic [SEG_W-1:0] SEG_DARK = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

   logic [PRE_W-1:0]      r_prescaler;
   digit_idx_t            r_digitIdx;
   logic [WORD_W-1:0]     r_displayReg;
   logic [WORD_W-1:0]     r_pendingReg;
   logic                  r_pendingFull;
   logic                  r_bcdReady;
   logic [SEG_W-1:0]      r_seg;
   logic [BCD_DIGITS-1:0] r_an;
   logic                  r_digitErr;

   logic                  w_tick;
   logic                  w_frameEnd;
   logic                  w_accept;
   logic                  w_load;
   logic                  w_pendingFullNext;
   logic [WORD_W-1:0]     w_displayNext;
   logic [BCD_W-1:0]      w_curNibble;
   logic                  w_blank;
   logic [SEG_W-1:0]      w_glyph;

   // Slot timing and handshake decisions. The last prescaler count of the
   // last digit slot is the frame boundary, the only point where the
   // pending word may be promoted to the display. An accept and a load can
   // never coincide because ready is registered low whenever pending is full.
   always_comb begin
      w_tick            = (r_prescaler == PRE_LAST);
      w_frameEnd        = w_tick && (r_digitIdx == LAST_DIGIT);
      w_accept          = bcd_valid && r_bcdReady;
      w_load            = w_frameEnd && r_pendingFull;
      w_displayNext     = w_load ? r_pendingReg : r_displayReg;
      w_pendingFullNext = r_pendingFull;
      if (w_accept) begin
         w_pendingFullNext = 1'b1;
      end else if (w_load) begin
         w_pendingFullNext = 1'b0;
      end
   end

   // Pick the nibble belonging to the slot currently being scanned.
   always_comb begin
      w_curNibble = r_displayReg[3:0];
      case (r_digitIdx)
         2'd0:    w_curNibble = r_displayReg[3:0];
         2'd1:    w_curNibble = r_displayReg[7:4];
         2'd2:    w_curNibble = r_displayReg[11:8];
         default: w_curNibble = r_displayReg[15:12];
      endcase
   end

`ifdef LEADING_ZERO_BLANK_EN
   // A digit is a leading zero when it and every more significant digit
   // are zero. The ones slot is never blanked so zero still reads "0".
   always_comb begin
      w_blank = 1'b0;
      case (r_digitIdx)
         2'd3:    w_blank = (r_displayReg[15:12] == 4'h0);
         2'd2:    w_blank = (r_displayReg[15:8] == 8'h00);
         2'd1:    w_blank = (r_displayReg[15:4] == 12'h000);
         default: w_blank = 1'b0;
      endcase
   end
`else
   // Every digit is shown, leading zeros included.
   assign w_blank = 1'b0;
`endif

   bcd_to_seg7 u_bcdToSeg7 (
      .i_nibble (w_curNibble),
      .i_blank  (w_blank),
      .o_glyph  (w_glyph)
   );

   // Prescaler and digit counter. The digit index moves on to the next slot
   // on every prescaler wrap and wraps itself after the thousands digit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prescaler <= '0;
         r_digitIdx  <= '0;
      end else begin
         if (w_tick) begin
            r_prescaler <= '0;
            r_digitIdx  <= r_digitIdx + 2'd1;
         end else begin
            r_prescaler <= r_prescaler + PRE_W'(1);
         end
      end
   end

   // Pending and display storage. An accepted word waits in the pending
   // register; ready is the registered complement of the next full flag, so
   // it drops the cycle after an accept and returns the cycle after the
   // boundary that empties the slot. Reset discards any waiting word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pendingReg  <= '0;
         r_pendingFull <= 1'b0;
         r_displayReg  <= '0;
         r_bcdReady    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_pendingReg <= bcd_number;
         end
         r_pendingFull <= w_pendingFullNext;
         r_displayReg  <= w_displayNext;
         r_bcdReady    <= ~w_pendingFullNext;
      end
   end

   // Output registers. an/seg follow the current slot, so they show a new
   // slot one cycle after the digit index moves. The error flag is taken
   // from the word being written into the display register so it changes
   // on the same edge as the display word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_an       <= '1;
         r_seg      <= SEG_DARK;
         r_digitErr <= 1'b0;
      end else begin
         r_an       <= anForDigit(r_digitIdx);
         r_seg      <= SEG_ACTIVE_LOW ? ~w_glyph : w_glyph;
         r_digitErr <= hasBadNibble(w_displayNext);
      end
   end

   assign bcd_ready = r_bcdReady;
   assign seg       = r_seg;
   assign an        = r_an;
   assign digit_err = r_digitErr;

endmodule
